gram64_reader: RTL and testbench
================================

Name: gram64_reader

Overview:
- Streaming read initiator for the 64-word x 16-bit gram64 memory.
- On `start`, walks `count` consecutive addresses from `base_addr` and reads each word over gram64's combinational read port (`address` -> `out_w`).
- Presents each word with its address on a valid/ready output stream, then pulses `done`.
- Sits between gram64 and any consumer, for example instruction fetch or a block copy. It never writes memory.

Parameters:
- AW, 6, address width; memory depth is 2**AW.
- DW, 16, data word width.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
- base_addr  input  AW  first address of the burst; sampled with start.
- count  input  AW+1  number of words, 0..64; sampled with start.
- abort  input  1  terminate the burst immediately.
- mem_address  output  AW  address to gram64; driven from the internal pointer register.
- mem_load  output  1  gram64 write enable; constant 0.
- mem_out_w  input  DW  gram64 read data; valid in the same cycle as mem_address.
- rd_data  output  DW  captured word.
- rd_addr  output  AW  address rd_data was read from.
- rd_valid  output  1  rd_data/rd_addr hold a word.
- rd_ready  input  1  consumer accepts the word.
- busy  output  1  high in RUN or DRAIN.
- done  output  1  one-cycle pulse when a burst completes normally.

Behaviour:
- Reset values (asynchronous, reset_n=0):
  - state=IDLE; ptr=0, so mem_address=0.
  - remaining=0; rd_data=0; rd_addr=0.
  - rd_valid=0; busy=0; done=0; mem_load=0 always.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - start=1 and count>0: ptr<=base_addr, remaining<=count, go to RUN.
  - start=1 and count=0: done=1 on the next cycle, stay in IDLE, no words output.
- RUN:
  - Capture condition: cap = (!rd_valid || rd_ready).
  - On cap: rd_data<=mem_out_w, rd_addr<=ptr, rd_valid<=1, ptr<=ptr+1 (mod 2**AW, so 63 wraps to 0), remaining<=remaining-1.
  - If remaining==1 on a capture, go to DRAIN.
  - Throughput is 1 word/cycle while rd_ready=1.
  - Latency: first rd_valid=1 on the second rising edge after the start edge (one cycle in RUN).
- Output holding:
  - While rd_valid=1 and rd_ready=0, rd_data and rd_addr hold and ptr holds.
  - rd_ready with rd_valid=0 has no effect.
- DRAIN: when rd_valid && rd_ready, clear rd_valid, pulse done for one cycle, go to IDLE.
- busy = (state != IDLE).
- start while busy is ignored; base_addr and count are ignored outside IDLE.
- abort (any state, priority over start/capture):
  - Next cycle: rd_valid=0, state=IDLE, remaining=0.
  - No done pulse; ptr keeps its value.
- A burst of count=64 reads every location exactly once and ends with ptr back at base_addr.
- reset_n asserted mid-burst: all state returns to reset values immediately; no done pulse.
- The read path is combinational from the memory only (mem_out_w -> rd_data register); rd_ready feeds only enables, never mem_address.

Decomposition:
- Shared package gram_pkg:
  - localparams GRAM_AW=6 and GRAM_DW=16.
  - State encoding rd_state_t: IDLE=2'd0, RUN=2'd1, DRAIN=2'd2.
- No sub-module; the FSM, pointer/counter and output register stay in one module.
- The bench instantiates gram64 alongside the reader and muxes gram64's address and load between its own preload writes and the DUT.

Test Plan:
1. Preload mem[k]=16'h1000+k for all k. start, base_addr=0, count=4, rd_ready=1 -> rd_valid for 4 consecutive cycles with (rd_addr, rd_data) = (0, 1000), (1, 1001), (2, 1002), (3, 1003); done one cycle after the last accept; busy low after done.
2. Wrap-around: base_addr=62, count=4 -> rd_addr sequence 62, 63, 0, 1 with data 103E, 103F, 1000, 1001; one done pulse.
3. Backpressure: base_addr=8, count=3, rd_ready toggling 1,0,0,1,0,1 -> each word held stable while stalled; outputs are 1008, 1009, 100A in order with no duplicates or drops; done only after the third accept.
4. Edge counts:
   - count=0 -> done pulse next cycle, rd_valid stays 0, busy stays 0.
   - count=64 from base 5 -> 64 words, addresses 5..63 then 0..4.
5. abort during word 2 of a count=10 burst -> rd_valid=0 and busy=0 next cycle, no done; a following start with base 0, count 1 returns 1000.
6. reset_n pulled low mid-burst (async, between edges) -> rd_valid, busy, done and mem_address go to 0 immediately; a start after release behaves as in scenario 1.

Source files
------------

// File: rtl/gram64_reader_pkg.sv
// Shared definitions for the gram64 memory and its streaming reader.
package gram_pkg;

    localparam int GRAM_AW = 6;
    localparam int GRAM_DW = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

endpackage

// File: rtl/gram64_reader_if.sv
// Memory read port plus valid/ready word stream between the reader and its neighbours.
interface gram64_reader_if #(
    parameter int AW = 6,
    parameter int DW = 16
);
    logic [AW-1:0] mem_address;
    logic          mem_load;
    logic [DW-1:0] mem_out_w;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] rd_addr;
    logic          rd_valid;
    logic          rd_ready;

    modport master (
        output mem_address, mem_load, rd_data, rd_addr, rd_valid,
        input  mem_out_w, rd_ready
    );

    modport slave (
        input  mem_address, mem_load, rd_data, rd_addr, rd_valid,
        output mem_out_w, rd_ready
    );
endinterface

// File: rtl/gram64.sv
// 2**AW x DW word memory: synchronous write on load, combinational read.
module gram64
    import gram_pkg::*;
#(
    parameter int AW = GRAM_AW,
    parameter int DW = GRAM_DW
) (
    input  logic          clk,
    input  logic [AW-1:0] address,
    input  logic [DW-1:0] in_w,
    input  logic          load,
    output logic [DW-1:0] out_w
);
    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (load) mem[address] <= in_w;
    end

    assign out_w = mem[address];
endmodule

// File: rtl/gram64_reader.sv
// Burst read initiator: walks count addresses from base_addr and streams (addr, word) pairs.
module gram64_reader
    import gram_pkg::*;
#(
    parameter int AW = GRAM_AW,
    parameter int DW = GRAM_DW
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [AW-1:0]   base_addr,
    input  logic [AW:0]     count,
    input  logic            abort,
    output logic            busy,
    output logic            done,
    gram64_reader_if.master bus
);
    rd_state_t     state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW:0]   rem_q, rem_d;
    logic [DW-1:0] data_q, data_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          valid_q, valid_d;
    logic          done_q, done_d;
    logic          cap;

    // A new word may be captured whenever the output slot is empty or being drained.
    assign cap = !valid_q || bus.rd_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        data_d  = data_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        if (abort) begin
            // Pointer is deliberately left where the burst stopped.
            state_d = IDLE;
            rem_d   = '0;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        if (count != '0) begin
                            ptr_d   = base_addr;
                            rem_d   = count;
                            state_d = RUN;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (cap) begin
                        data_d  = bus.mem_out_w;
                        addr_d  = ptr_q;
                        valid_d = 1'b1;
                        ptr_d   = ptr_q + 1'b1;
                        rem_d   = rem_q - 1'b1;
                        if (rem_q == (AW+1)'(1)) state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (valid_q && bus.rd_ready) begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.mem_address = ptr_q;
    assign bus.mem_load    = 1'b0;
    assign bus.rd_data     = data_q;
    assign bus.rd_addr     = addr_q;
    assign bus.rd_valid    = valid_q;
    assign busy            = (state_q != IDLE);
    assign done            = done_q;
endmodule

// File: tb/tb_gram64_reader.sv
// Randomized bench for gram64_reader against a queue-based model of the burst stream.
module tb_gram64_reader;
    import gram_pkg::*;

    localparam int AW = GRAM_AW;
    localparam int DW = GRAM_DW;
    localparam int DEPTH = 2**AW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   count = '0;
    logic          abort = 1'b0;
    logic          busy, done;

    logic          pre = 1'b0;
    logic          pre_load = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;
    logic [DW-1:0] gram_out;

    logic [DW-1:0] mem_model [DEPTH];
    int n_chk = 0;
    int n_pass = 0;

    gram64_reader_if #(.AW(AW), .DW(DW)) bus ();

    gram64 #(.AW(AW), .DW(DW)) u_mem (
        .clk     (clk),
        .address (pre ? pre_addr : bus.mem_address),
        .in_w    (pre_data),
        .load    (pre ? pre_load : bus.mem_load),
        .out_w   (gram_out)
    );
    assign bus.mem_out_w = gram_out;

    gram64_reader #(.AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .bus       (bus.master)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic preload(input bit rnd);
        pre = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            mem_model[k] = rnd ? DW'($urandom) : DW'(16'h1000 + k);
            pre_addr = AW'(k);
            pre_data = mem_model[k];
            pre_load = 1'b1;
            @(posedge clk); #1;
        end
        pre_load = 1'b0;
        pre = 1'b0;
    endtask

    function automatic logic pick_ready(input int mode, input int cyc);
        logic [5:0] pat;
        pat = 6'b101001;    // 1,0,0,1,0,1 read from bit 0 upwards
        case (mode)
            0: return 1'b1;
            1: return 1'($urandom_range(0, 1));
            default: return pat[cyc % 6];
        endcase
    endfunction

    // Drives one burst and checks every accepted word, stall stability, done and end state.
    task automatic run_burst(input int base, input int cnt, input int rmode, input string tag);
        logic [AW-1:0] exp_a [$];
        logic [DW-1:0] exp_d [$];
        logic [DW-1:0] hd;
        logic [AW-1:0] ha;
        bit held = 0;
        int got = 0, cyc = 0, dones = 0;
        for (int i = 0; i < cnt; i++) begin
            exp_a.push_back(AW'((base + i) % DEPTH));
            exp_d.push_back(mem_model[(base + i) % DEPTH]);
        end
        @(posedge clk); #1;
        start = 1'b1; base_addr = AW'(base); count = (AW+1)'(cnt);
        bus.rd_ready = pick_ready(rmode, cyc);
        while (cyc < 400) begin
            @(negedge clk);
            if (held) begin
                check({tag, "_hold_v"}, 32'(bus.rd_valid), 32'd1);
                check({tag, "_hold_d"}, 32'({bus.rd_addr, bus.rd_data}), 32'({ha, hd}));
            end
            if (bus.rd_valid && bus.rd_ready) begin
                if (exp_a.size() == 0) begin
                    check({tag, "_extra_word"}, 32'(got + 1), 32'(cnt));
                end else begin
                    check({tag, "_addr"}, 32'(bus.rd_addr), 32'(exp_a.pop_front()));
                    check({tag, "_data"}, 32'(bus.rd_data), 32'(exp_d.pop_front()));
                end
                got++;
            end
            held = bus.rd_valid && !bus.rd_ready;
            ha = bus.rd_addr; hd = bus.rd_data;
            if (done) begin
                dones++;
                check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
                check({tag, "_valid_at_done"}, 32'(bus.rd_valid), 32'd0);
                break;
            end
            if (cnt == 0) check({tag, "_busy0"}, 32'(busy), 32'd0);
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
            bus.rd_ready = pick_ready(rmode, cyc);
        end
        start = 1'b0;
        check({tag, "_done_seen"}, 32'(dones), 32'd1);
        check({tag, "_words"}, 32'(got), 32'(cnt));
        if (cnt > 0) check({tag, "_ptr_end"}, 32'(bus.mem_address), 32'((base + cnt) % DEPTH));
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        bus.rd_ready = 1'b1;
        #2;
        check("rst_valid", 32'(bus.rd_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_addr", 32'(bus.mem_address), 32'd0);
        check("rst_rdata", 32'({bus.rd_addr, bus.rd_data}), 32'd0);
        check("rst_load", 32'(bus.mem_load), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        preload(0);

        run_burst(0, 4, 0, "s1");
        run_burst(62, 4, 0, "s2_wrap");
        run_burst(8, 3, 2, "s3_bp");
        run_burst(0, 0, 0, "s4_zero");
        run_burst(5, 64, 0, "s4_full");
        run_burst(17, 64, 1, "s4_full_rnd");

        // Abort while the second word is on the output.
        @(posedge clk); #1;
        start = 1'b1; base_addr = '0; count = 7'd10; bus.rd_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        begin
            int w = 0;
            while (w < 20 && !(bus.rd_valid && bus.rd_addr == AW'(1))) begin
                @(negedge clk); w++;
            end
            check("s5_reach_word2", 32'(w < 20), 32'd1);
        end
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("s5_valid", 32'(bus.rd_valid), 32'd0);
        check("s5_busy", 32'(busy), 32'd0);
        check("s5_done", 32'(done), 32'd0);
        @(negedge clk);
        check("s5_done2", 32'(done), 32'd0);
        run_burst(0, 1, 0, "s5_after");

        // Asynchronous reset between edges, mid-burst.
        @(posedge clk); #1;
        start = 1'b1; base_addr = AW'(20); count = 7'd20; bus.rd_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("s6_valid", 32'(bus.rd_valid), 32'd0);
        check("s6_busy", 32'(busy), 32'd0);
        check("s6_done", 32'(done), 32'd0);
        check("s6_addr", 32'(bus.mem_address), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        run_burst(0, 4, 0, "s6_after");

        // Random contents, random bursts and random backpressure.
        preload(1);
        for (int t = 0; t < 8; t++) begin
            int b, c;
            b = $urandom_range(0, DEPTH - 1);
            c = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, DEPTH);
            run_burst(b, c, $urandom_range(0, 2), $sformatf("rnd%0d", t));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
